scan_mux: RTL

Parametrised digit scanner: selects one of `CHANNELS` grey-coded multi-digit readings and snapshots it once per frame. It then time-multiplexes the digits, most-significant first, followed by a decimal-point separator slot, onto a single 5-bit grey bus feeding the `LED` decoder. It sits between the ring-oscillator counter banks and the LED driver. Generalises the fixed 10-channel, 3-digit scanner with these additions:
- run-time hold;
- leading-zero blanking;
- frame/slot outputs;
- exact `DWELL`-cycle slot timing.

---
 rtl/scan_mux.sv | 124 ++++++++++++
 1 files changed

// File: rtl/scan_mux.sv
// scan_mux: snapshots one of CHANNELS grey-coded readings per frame and scans its digits (MSD first) plus a DP slot onto o_grey.
// Latency: run enable 8 edges after reset release; snapshot to first digit is DWELL cycles; each slot lasts DWELL cycles.
// Backpressure: none; free-running display scanner. i_hold freezes the snapshot at DP entry.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_sel/i_hold/i_digits channel select, freeze, flattened readings;
//        o_grey slot code, o_slot slot index (DIGITS = DP slot), o_frame one-cycle pulse on slot-0 entry.
module scan_mux #(
    parameter int CHANNELS = 10,
    parameter int DIGITS   = 3,
    parameter int DWELL    = 20000,
    parameter int SEL_W    = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [SEL_W-1:0]               i_sel,
    input  logic                           i_hold,
    input  logic [CHANNELS*DIGITS*5-1:0]   i_digits,
    output logic [4:0]                     o_grey,
    output logic [$clog2(DIGITS+1)-1:0]    o_slot,
    output logic                           o_frame
);

    localparam int SLOT_W = $clog2(DIGITS + 1);
    localparam int CNT_W  = $clog2(DWELL);

    localparam logic [4:0] GREY_ZERO  = 5'b10001;
    localparam logic [4:0] GREY_DP    = 5'b10101;
    localparam logic [4:0] GREY_BLANK = 5'b00000;

    localparam logic [SLOT_W-1:0] SLOT_DP = SLOT_W'(DIGITS);
    localparam logic [CNT_W-1:0]  CNT_TC  = CNT_W'(DWELL - 1);

    logic [7:0]                  stretch;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic [DIGITS-1:0][4:0]      snap, snap_nxt;
    logic [DIGITS-1:0][4:0]      cap;
    logic [DIGITS-1:0]           blank;
    logic [4:0]                  grey_nxt;
    logic [SLOT_W-1:0]           slot_nxt, slot_adv;
    logic                        frame_nxt;
    logic                        run, start, term, lz_run;

    // Stretch register fills with ones after reset release; the edge that
    // sets its top bit is the start-up edge that enters the first DP slot.
    assign run   = stretch[7];
    assign start = stretch[6] & ~stretch[7];
    assign term  = (cnt == CNT_TC);

    // Capture source: selected channel, or DP in every digit when out of range.
    always_comb begin
        cap = {DIGITS{GREY_DP}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_sel == SEL_W'(c)) begin
                cap = i_digits[c*DIGITS*5 +: DIGITS*5];
            end
        end
    end

    // Digit d blanks while it and every more-significant digit are ZERO;
    // the last digit always shows so an all-zero reading reads "0".
    always_comb begin
        lz_run = 1'b1;
        blank  = '0;
        for (int d = 0; d < DIGITS; d++) begin
            lz_run   = lz_run & (snap[d] == GREY_ZERO);
            blank[d] = (BLANK_LZ != 0) && (d < DIGITS - 1) && lz_run;
        end
    end

    assign slot_adv = (o_slot == SLOT_DP) ? '0 : o_slot + 1'b1;

    always_comb begin
        cnt_nxt   = cnt;
        snap_nxt  = snap;
        slot_nxt  = o_slot;
        grey_nxt  = o_grey;
        frame_nxt = 1'b0;
        if (start) begin
            // First DP entry captures regardless of hold.
            cnt_nxt  = '0;
            slot_nxt = SLOT_DP;
            grey_nxt = GREY_DP;
            snap_nxt = cap;
        end else if (run) begin
            cnt_nxt = term ? '0 : cnt + 1'b1;
            if (term) begin
                slot_nxt = slot_adv;
                if (slot_adv == SLOT_DP) begin
                    grey_nxt = GREY_DP;
                    if (!i_hold) begin
                        snap_nxt = cap;
                    end
                end else begin
                    grey_nxt  = GREY_BLANK;
                    frame_nxt = (slot_adv == '0);
                    for (int d = 0; d < DIGITS; d++) begin
                        if (slot_adv == SLOT_W'(d)) begin
                            grey_nxt = blank[d] ? GREY_BLANK : snap[d];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stretch <= '0;
            cnt     <= '0;
            snap    <= '0;
            o_grey  <= GREY_BLANK;
            o_slot  <= '0;
            o_frame <= 1'b0;
        end else begin
            stretch <= {stretch[6:0], 1'b1};
            cnt     <= cnt_nxt;
            snap    <= snap_nxt;
            o_grey  <= grey_nxt;
            o_slot  <= slot_nxt;
            o_frame <= frame_nxt;
        end
    end

endmodule
